// File: rtl/trg_decode_pipe_if.sv
// Trigger decoder bus: ENC_TRG/config inputs and decoded strobes/counters.
// The master modport drives the trigger inputs. The slave modport is the decoder side.
interface trg_decode_pipe_if #(
  parameter int XDLY_W = 2,
  parameter int CNT_W  = 16,
  parameter int ERR_W  = 8
);
  logic [2:0]        ENC_TRG;
  logic              ENCODE;
  logic [XDLY_W-1:0] XL1A_DLY;
  logic              LCT;
  logic              L1A;
  logic              L1A_MATCH;
  logic              RESYNC;
  logic              ILLEGAL;
  logic [CNT_W-1:0]  LCT_CNT;
  logic [CNT_W-1:0]  L1A_CNT;
  logic [ERR_W-1:0]  ERR_CNT;

  modport master (
    output ENC_TRG, ENCODE, XL1A_DLY,
    input  LCT, L1A, L1A_MATCH, RESYNC, ILLEGAL, LCT_CNT, L1A_CNT, ERR_CNT
  );

  modport slave (
    input  ENC_TRG, ENCODE, XL1A_DLY,
    output LCT, L1A, L1A_MATCH, RESYNC, ILLEGAL, LCT_CNT, L1A_CNT, ERR_CNT
  );
endinterface

// File: rtl/trg_decode_pipe.sv
// ENC_TRG decoder: input register, decode register, programmable L1A delay line,
// resync length filter, and LCT/L1A/illegal-code counters. All logic runs on CMSCLK.
module trg_decode_pipe #(
  parameter int MAX_XDLY = 3,
  parameter int XDLY_W   = 2,
  parameter int RS_MIN   = 4,
  parameter int CNT_W    = 16,
  parameter int ERR_W    = 8
) (
  input  logic              CMSCLK,
  input  logic              RST_B,
  trg_decode_pipe_if.slave  bus
);

  localparam int                RS_W    = $clog2(RS_MIN + 1);
  localparam logic [RS_W-1:0]   RS_FULL = RS_W'(RS_MIN);
  localparam logic [XDLY_W-1:0] MAX_DLY = XDLY_W'(MAX_XDLY);

  logic [2:0]          s1_trg;
  logic                s1_enc;
  logic                dec_lct, dec_l1a, dec_match, dec_rs, dec_ill;
  logic                s2_lct, s2_l1a, s2_match, s2_ill;
  logic [RS_W-1:0]     rs_cnt;
  logic [MAX_XDLY-1:0] dl_l1a, dl_match;
  logic [MAX_XDLY:0]   l1a_tap, match_tap;
  logic [XDLY_W-1:0]   dly_sel;
  logic                resync_nxt, lct_nxt, l1a_nxt, match_nxt;

  // NOTE: every signal gets a default before the case so no latch is inferred.
  always_comb begin
    dec_lct   = 1'b0;
    dec_l1a   = 1'b0;
    dec_match = 1'b0;
    dec_rs    = 1'b0;
    dec_ill   = 1'b0;
    if (s1_enc) begin
      case (s1_trg)
        3'd1: dec_lct = 1'b1;
        3'd2: begin dec_l1a = 1'b1; dec_lct = 1'b1; end
        3'd3: begin dec_match = 1'b1; dec_l1a = 1'b1; dec_lct = 1'b1; end
        3'd4: dec_l1a = 1'b1;
        3'd5: begin dec_match = 1'b1; dec_l1a = 1'b1; end
        3'd6: dec_ill = 1'b1;
        3'd7: dec_rs = 1'b1;
        default: ;
      endcase
    end else begin
      dec_lct   = s1_trg[0];
      dec_l1a   = s1_trg[1];
      dec_rs    = s1_trg[2];
      dec_match = s1_trg[0] & s1_trg[1];
    end
    // A resync sample carries no strobes, so a short burst leaves no trace.
    if (dec_rs) begin
      dec_lct   = 1'b0;
      dec_l1a   = 1'b0;
      dec_match = 1'b0;
    end
  end

  // Gating uses the next RESYNC value so the first trigger after release is not lost.
  assign resync_nxt = (rs_cnt == RS_FULL);
  assign dly_sel    = (bus.XL1A_DLY > MAX_DLY) ? MAX_DLY : bus.XL1A_DLY;
  assign l1a_tap    = {dl_l1a, s2_l1a};
  assign match_tap  = {dl_match, s2_match};
  assign lct_nxt    = s2_lct & ~resync_nxt;
  assign l1a_nxt    = l1a_tap[dly_sel] & ~resync_nxt;
  assign match_nxt  = match_tap[dly_sel] & ~resync_nxt;

  // NOTE: sequential state uses non-blocking assignments only, so stage order does not matter.
  always_ff @(posedge CMSCLK or negedge RST_B) begin
    if (!RST_B) begin
      s1_trg   <= 3'd0;
      s1_enc   <= 1'b0;
      s2_lct   <= 1'b0;
      s2_l1a   <= 1'b0;
      s2_match <= 1'b0;
      s2_ill   <= 1'b0;
      rs_cnt   <= '0;
    end else begin
      s1_trg   <= bus.ENC_TRG;
      s1_enc   <= bus.ENCODE;
      s2_lct   <= dec_lct;
      s2_l1a   <= dec_l1a;
      s2_match <= dec_match;
      s2_ill   <= dec_ill;
      if (!dec_rs)
        rs_cnt <= '0;
      else if (rs_cnt != RS_FULL)
        rs_cnt <= rs_cnt + RS_W'(1);
    end
  end

  // Delay line: tap k holds the decoded L1A k+1 cycles after the decode register.
  always_ff @(posedge CMSCLK or negedge RST_B) begin
    if (!RST_B) begin
      dl_l1a   <= '0;
      dl_match <= '0;
    end else if (resync_nxt) begin
      dl_l1a   <= '0;
      dl_match <= '0;
    end else begin
      dl_l1a[0]   <= s2_l1a;
      dl_match[0] <= s2_match;
      for (int k = 1; k < MAX_XDLY; k++) begin
        dl_l1a[k]   <= dl_l1a[k-1];
        dl_match[k] <= dl_match[k-1];
      end
    end
  end

  always_ff @(posedge CMSCLK or negedge RST_B) begin
    if (!RST_B) begin
      bus.LCT       <= 1'b0;
      bus.L1A       <= 1'b0;
      bus.L1A_MATCH <= 1'b0;
      bus.RESYNC    <= 1'b0;
      bus.ILLEGAL   <= 1'b0;
      bus.LCT_CNT   <= '0;
      bus.L1A_CNT   <= '0;
      bus.ERR_CNT   <= '0;
    end else begin
      bus.LCT       <= lct_nxt;
      bus.L1A       <= l1a_nxt;
      bus.L1A_MATCH <= match_nxt;
      bus.RESYNC    <= resync_nxt;
      bus.ILLEGAL   <= s2_ill;
      if (resync_nxt) begin
        bus.LCT_CNT <= '0;
        bus.L1A_CNT <= '0;
      end else begin
        bus.LCT_CNT <= bus.LCT_CNT + CNT_W'(lct_nxt);
        bus.L1A_CNT <= bus.L1A_CNT + CNT_W'(l1a_nxt);
      end
      if (s2_ill && (bus.ERR_CNT != '1))
        bus.ERR_CNT <= bus.ERR_CNT + ERR_W'(1);
    end
  end

endmodule

// File: tb/tb_trg_decode_pipe.sv
// Directed bench for trg_decode_pipe: hand-computed strobe timing, resync filter,
// illegal-code saturation, direct mode, and mid-flight reset.
module tb_trg_decode_pipe;

  typedef logic [2:0] vec10_t [10];

  logic CMSCLK = 1'b0;
  logic RST_B  = 1'b0;
  int   n_pass  = 0;
  int   n_total = 0;

  trg_decode_pipe_if #(.XDLY_W(2), .CNT_W(16), .ERR_W(8)) bus ();

  trg_decode_pipe #(
    .MAX_XDLY(3), .XDLY_W(2), .RS_MIN(4), .CNT_W(16), .ERR_W(8)
  ) dut (
    .CMSCLK (CMSCLK),
    .RST_B  (RST_B),
    .bus    (bus)
  );

  always #5 CMSCLK = ~CMSCLK;

  task automatic tick();
    @(posedge CMSCLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic do_reset();
    bus.ENC_TRG = 3'd0;
    RST_B = 1'b0;
    tick();
    tick();
    RST_B = 1'b1;
  endtask

  // codes[k] is sampled at edge k; exp[k] is {LCT,L1A,L1A_MATCH} just after edge k.
  task automatic apply(input string tag, input vec10_t codes, input vec10_t exp);
    bus.ENC_TRG = codes[0];
    for (int k = 0; k < 10; k++) begin
      tick();
      bus.ENC_TRG = (k < 9) ? codes[k+1] : 3'd0;
      check($sformatf("%s[%0d]", tag, k), {29'd0, bus.LCT, bus.L1A, bus.L1A_MATCH}, {29'd0, exp[k]});
    end
  endtask

  initial begin
    int ill_seen;
    int strobes;
    bus.ENC_TRG  = 3'd0;
    bus.ENCODE   = 1'b1;
    bus.XL1A_DLY = 2'd1;
    tick();
    check("rst_lct",    bus.LCT, 0);
    check("rst_l1a",    bus.L1A, 0);
    check("rst_resync", bus.RESYNC, 0);
    check("rst_ill",    bus.ILLEGAL, 0);
    check("rst_lctcnt", bus.LCT_CNT, 0);
    check("rst_errcnt", bus.ERR_CNT, 0);
    tick();
    RST_B = 1'b1;

    // Test 1: code 3, extra delay 1.
    apply("t1", '{3'd3, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0},
                '{3'b000, 3'b000, 3'b100, 3'b011, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000});
    check("t1_lctcnt", bus.LCT_CNT, 1);
    check("t1_l1acnt", bus.L1A_CNT, 1);

    // Test 2: back-to-back codes 1,2,4,5.
    do_reset();
    apply("t2", '{3'd1, 3'd2, 3'd4, 3'd5, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0},
                '{3'b000, 3'b000, 3'b100, 3'b100, 3'b010, 3'b010, 3'b011, 3'b000, 3'b000, 3'b000});
    check("t2_lctcnt", bus.LCT_CNT, 2);
    check("t2_l1acnt", bus.L1A_CNT, 3);

    // Test 3: short resync burst is discarded, long burst asserts RESYNC and clears counters.
    do_reset();
    apply("t3_pre", '{3'd1, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0},
                    '{3'b000, 3'b000, 3'b100, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000});
    check("t3_lctcnt_pre", bus.LCT_CNT, 1);
    bus.ENC_TRG = 3'd7;
    for (int k = 0; k < 10; k++) begin
      tick();
      bus.ENC_TRG = (k + 1 < 3) ? 3'd7 : 3'd0;
      check($sformatf("t3_short[%0d]", k), bus.RESYNC, 0);
    end
    check("t3_lctcnt_short", bus.LCT_CNT, 1);
    bus.ENC_TRG = 3'd7;
    for (int k = 0; k < 30; k++) begin
      tick();
      bus.ENC_TRG = (k + 1 < 25) ? 3'd7 : 3'd0;
      check($sformatf("t3_long[%0d]", k), bus.RESYNC, (k >= 5 && k <= 26) ? 1 : 0);
      if (k == 10) check("t3_lctcnt_mid", bus.LCT_CNT, 0);
    end
    check("t3_lctcnt", bus.LCT_CNT, 0);
    check("t3_l1acnt", bus.L1A_CNT, 0);

    // Test 4: 300 illegal codes, ERR_CNT saturates at 255.
    do_reset();
    ill_seen = 0;
    strobes  = 0;
    bus.ENC_TRG = 3'd6;
    for (int k = 0; k < 310; k++) begin
      tick();
      bus.ENC_TRG = (k + 1 < 300) ? 3'd6 : 3'd0;
      ill_seen += int'(bus.ILLEGAL);
      strobes  += int'(bus.LCT | bus.L1A | bus.L1A_MATCH);
      if (k == 255) check("t4_err_254", bus.ERR_CNT, 254);
      if (k == 256) check("t4_err_255", bus.ERR_CNT, 255);
    end
    check("t4_ill_pulses", ill_seen, 300);
    check("t4_errcnt", bus.ERR_CNT, 255);
    check("t4_strobes", strobes, 0);

    // Test 5: direct mode with maximum delay, rs suppression, and zero delay.
    do_reset();
    bus.ENCODE   = 1'b0;
    bus.XL1A_DLY = 2'd3;
    apply("t5_dir", '{3'b011, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0},
                    '{3'b000, 3'b000, 3'b100, 3'b000, 3'b000, 3'b011, 3'b000, 3'b000, 3'b000, 3'b000});
    apply("t5_l1a", '{3'b010, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0},
                    '{3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b010, 3'b000, 3'b000, 3'b000, 3'b000});
    apply("t5_rs",  '{3'b111, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0},
                    '{3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000});
    check("t5_lctcnt", bus.LCT_CNT, 1);
    check("t5_l1acnt", bus.L1A_CNT, 2);
    bus.ENCODE   = 1'b1;
    bus.XL1A_DLY = 2'd0;
    apply("t5_d0",  '{3'd3, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0},
                    '{3'b000, 3'b000, 3'b111, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000});

    // Test 6: reset while an L1A sits in the delay line.
    do_reset();
    bus.XL1A_DLY = 2'd3;
    bus.ENC_TRG  = 3'd4;
    tick();
    bus.ENC_TRG = 3'd0;
    tick();
    tick();
    RST_B = 1'b0;
    #1;
    check("t6_l1acnt_async", bus.L1A_CNT, 0);
    tick();
    RST_B = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      check($sformatf("t6_l1a[%0d]", k), bus.L1A, 0);
    end
    check("t6_lctcnt", bus.LCT_CNT, 0);
    check("t6_l1acnt", bus.L1A_CNT, 0);
    check("t6_errcnt", bus.ERR_CNT, 0);
    apply("t6_post", '{3'd1, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0},
                     '{3'b000, 3'b000, 3'b100, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000});

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
